// File: rtl/cpu_state_dumper.sv
// Snapshot engine: streams PC, register file and a data-memory window as tagged valid/ready words.
// Define DUMP_CHECKSUM_EN to append an XOR checksum word (tag 3) after the last memory word.
module cpu_state_dumper #(
  parameter int DATA_W    = 32,
  parameter int NUM_REGS  = 32,
  parameter int MEM_WORDS = 32,
  parameter int IDX_W     = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              trig_i,
  input  logic [DATA_W-1:0] pc_i,
  output logic [IDX_W-1:0]  reg_addr_o,
  input  logic [DATA_W-1:0] reg_data_i,
  output logic [IDX_W-1:0]  mem_addr_o,
  input  logic [DATA_W-1:0] mem_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [1:0]        out_tag_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              trig_lost_o
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_PC   = 3'd1;
  localparam logic [2:0] S_REG  = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
`ifdef DUMP_CHECKSUM_EN
  localparam logic [2:0] S_CSUM = 3'd4;
  localparam logic [1:0] TAG_CSUM = 2'd3;
`endif
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [1:0] TAG_PC  = 2'd0;
  localparam logic [1:0] TAG_REG = 2'd1;
  localparam logic [1:0] TAG_MEM = 2'd2;

  localparam logic [IDX_W-1:0] LAST_REG = IDX_W'(NUM_REGS - 1);
  localparam logic [IDX_W-1:0] LAST_MEM = IDX_W'(MEM_WORDS - 1);
  localparam logic [IDX_W-1:0] ONE      = IDX_W'(1);

  logic [2:0]       state;
  logic             xfer;
  logic [IDX_W-1:0] next_reg;
  logic [IDX_W-1:0] next_mem;

  assign xfer     = out_valid_o & out_ready_i;
  assign next_reg = (reg_addr_o == LAST_REG) ? '0 : reg_addr_o + ONE;
  assign next_mem = (mem_addr_o == LAST_MEM) ? '0 : mem_addr_o + ONE;
  assign busy_o   = (state != S_IDLE);
  assign done_o   = (state == S_DONE);

`ifdef DUMP_CHECKSUM_EN
  logic [DATA_W-1:0] csum;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      csum <= '0;
    end else if (state == S_IDLE && trig_i) begin
      csum <= '0;
    end else if (xfer && (state == S_PC || state == S_REG || state == S_MEM)) begin
      csum <= csum ^ out_data_o;
    end
  end
`endif

  // Address registers run one entry ahead of the output register so the
  // combinational read data is already valid at the edge that loads it.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      out_valid_o <= 1'b0;
      out_data_o  <= '0;
      out_tag_o   <= '0;
      out_idx_o   <= '0;
      reg_addr_o  <= '0;
      mem_addr_o  <= '0;
      trig_lost_o <= 1'b0;
    end else begin
      if (trig_i && state != S_IDLE && state != S_DONE)
        trig_lost_o <= 1'b1;

      case (state)
        S_IDLE: begin
          if (trig_i) begin
            state       <= S_PC;
            out_valid_o <= 1'b1;
            out_data_o  <= pc_i;
            out_tag_o   <= TAG_PC;
            out_idx_o   <= '0;
            reg_addr_o  <= '0;
            mem_addr_o  <= '0;
          end
        end
        S_PC: begin
          if (xfer) begin
            state      <= S_REG;
            out_data_o <= reg_data_i;
            out_tag_o  <= TAG_REG;
            out_idx_o  <= reg_addr_o;
            reg_addr_o <= next_reg;
          end
        end
        S_REG: begin
          if (xfer) begin
            if (out_idx_o == LAST_REG) begin
              state      <= S_MEM;
              out_data_o <= mem_data_i;
              out_tag_o  <= TAG_MEM;
              out_idx_o  <= mem_addr_o;
              mem_addr_o <= next_mem;
            end else begin
              out_data_o <= reg_data_i;
              out_idx_o  <= reg_addr_o;
              reg_addr_o <= next_reg;
            end
          end
        end
        S_MEM: begin
          if (xfer) begin
            if (out_idx_o == LAST_MEM) begin
`ifdef DUMP_CHECKSUM_EN
              // Fold in the word leaving on this edge; the accumulator lags by one.
              state      <= S_CSUM;
              out_data_o <= csum ^ out_data_o;
              out_tag_o  <= TAG_CSUM;
              out_idx_o  <= '0;
`else
              state       <= S_DONE;
              out_valid_o <= 1'b0;
              out_data_o  <= '0;
              out_tag_o   <= '0;
              out_idx_o   <= '0;
`endif
            end else begin
              out_data_o <= mem_data_i;
              out_idx_o  <= mem_addr_o;
              mem_addr_o <= next_mem;
            end
          end
        end
`ifdef DUMP_CHECKSUM_EN
        S_CSUM: begin
          if (xfer) begin
            state       <= S_DONE;
            out_valid_o <= 1'b0;
            out_data_o  <= '0;
            out_tag_o   <= '0;
            out_idx_o   <= '0;
          end
        end
`endif
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state       <= S_IDLE;
          out_valid_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_state_dumper.sv
// Scoreboard bench for cpu_state_dumper: expected words are queued per dump and popped on each transfer.
module tb_cpu_state_dumper;

  localparam int DW = 32;
  localparam int NR = 4;
  localparam int NM = 4;
  localparam int IW = 8;

  typedef struct {
    logic [1:0]    tag;
    logic [IW-1:0] idx;
    logic [DW-1:0] data;
  } word_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          trig = 1'b0;
  logic [DW-1:0] pc = '0;
  logic [IW-1:0] reg_addr;
  logic [DW-1:0] reg_data;
  logic [IW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_tag;
  logic [IW-1:0] out_idx;
  logic          busy;
  logic          done;
  logic          trig_lost;

  logic [DW-1:0] regs [NR];
  logic [DW-1:0] mem  [NM];
  word_t         sb [$];
  int            n_compared = 0;
  int            n_mismatched = 0;

  always #5 clk = ~clk;

  assign reg_data = (int'(reg_addr) < NR) ? regs[int'(reg_addr)] : '0;
  assign mem_data = (int'(mem_addr) < NM) ? mem[int'(mem_addr)] : '0;

  cpu_state_dumper #(.DATA_W(DW), .NUM_REGS(NR), .MEM_WORDS(NM), .IDX_W(IW)) dut (
    .clk_i(clk), .rst_i(rst), .trig_i(trig), .pc_i(pc),
    .reg_addr_o(reg_addr), .reg_data_i(reg_data),
    .mem_addr_o(mem_addr), .mem_data_i(mem_data),
    .out_valid_o(out_valid), .out_ready_i(out_ready),
    .out_data_o(out_data), .out_tag_o(out_tag), .out_idx_o(out_idx),
    .busy_o(busy), .done_o(done), .trig_lost_o(trig_lost)
  );

  task automatic push_dump(input logic [DW-1:0] p);
    logic [DW-1:0] x;
    x = p;
    sb.push_back('{2'd0, '0, p});
    for (int i = 0; i < NR; i++) begin
      sb.push_back('{2'd1, IW'(i), regs[i]});
      x ^= regs[i];
    end
    for (int i = 0; i < NM; i++) begin
      sb.push_back('{2'd2, IW'(i), mem[i]});
      x ^= mem[i];
    end
`ifdef DUMP_CHECKSUM_EN
    sb.push_back('{2'd3, '0, x});
`endif
  endtask

  // Called just after a negedge; returns at the negedge following the last transfer.
  task automatic drain(input bit toggle, output int valid_cycles);
    int            cyc;
    bit            held;
    bit            rdy;
    word_t         exp;
    logic [DW+IW+1:0] prev;
    cyc = 0;
    held = 0;
    prev = '0;
    valid_cycles = 0;
    while (sb.size() > 0) begin
      if (cyc >= 400) begin
        n_compared++; n_mismatched++;
        $display("[TB] FAIL drain_timeout: %0d words still pending, expected 0", sb.size());
        sb.delete();
        break;
      end
      rdy = toggle ? bit'(cyc % 2) : 1'b1;
      out_ready = rdy;
      if (out_valid) begin
        valid_cycles++;
        if (held) begin
          n_compared++;
          if ({out_tag, out_idx, out_data} !== prev) begin
            n_mismatched++;
            $display("[TB] FAIL hold_stable: got %h, expected %h", {out_tag, out_idx, out_data}, prev);
          end
        end
        if (rdy) begin
          exp = sb.pop_front();
          held = 0;
          n_compared++;
          if (out_tag !== exp.tag || out_idx !== exp.idx || out_data !== exp.data) begin
            n_mismatched++;
            $display("[TB] FAIL word: got tag=%0d idx=%0d data=%h, expected tag=%0d idx=%0d data=%h",
                     out_tag, out_idx, out_data, exp.tag, exp.idx, exp.data);
          end
        end else begin
          held = 1;
          prev = {out_tag, out_idx, out_data};
        end
      end
      @(negedge clk);
      cyc++;
    end
    out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #3;
    n_compared++;
    if ({out_valid, out_data, out_tag, out_idx, reg_addr, mem_addr, busy, done, trig_lost} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_outputs: got %h, expected 0",
               {out_valid, out_data, out_tag, out_idx, reg_addr, mem_addr, busy, done, trig_lost});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic(input logic [DW-1:0] p);
    int vc;
    pc = p;
    push_dump(p);
    trig = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    n_compared++;
    if (out_valid !== 1'b1 || busy !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL trig_latency: got valid=%b busy=%b, expected 1 1", out_valid, busy);
    end
    drain(1'b0, vc);
    n_compared++;
    if (done !== 1'b1 || out_valid !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL done_pulse: got done=%b valid=%b, expected 1 0", done, out_valid);
    end
    @(negedge clk);
    n_compared++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL done_width: got done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_backpressure();
    int vc;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    for (int i = 0; i < NM; i++) mem[i] = $urandom;
    pc = 32'h0000_1234;
    push_dump(pc);
    trig = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    drain(1'b1, vc);
    n_compared++;
`ifdef DUMP_CHECKSUM_EN
    if (vc != 20) begin
      n_mismatched++;
      $display("[TB] FAIL valid_cycles: got %0d, expected 20", vc);
    end
`else
    if (vc != 18) begin
      n_mismatched++;
      $display("[TB] FAIL valid_cycles: got %0d, expected 18", vc);
    end
`endif
    n_compared++;
    if (done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL bp_done: got %b, expected 1", done);
    end
    @(negedge clk);
  endtask

  task automatic test_trig_held();
    int vc;
    pc = 32'h0000_0088;
    push_dump(pc);
    trig = 1'b1;
    @(negedge clk);
    n_compared++;
    if (trig_lost !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL lost_early: got %b, expected 0", trig_lost);
    end
    drain(1'b0, vc);
    n_compared++;
    if (trig_lost !== 1'b1 || done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL lost_set: got lost=%b done=%b, expected 1 1", trig_lost, done);
    end
    push_dump(pc);
    @(negedge clk);
    n_compared++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL idle_gap: got valid=%b busy=%b, expected 0 0", out_valid, busy);
    end
    @(negedge clk);
    trig = 1'b0;
    drain(1'b0, vc);
    n_compared++;
    if (trig_lost !== 1'b1 || done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL lost_sticky: got lost=%b done=%b, expected 1 1", trig_lost, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit saw_done;
    pc = 32'h0000_0040;
    trig = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    trig = 1'b0;
    cyc = 0;
    while (!(out_tag == 2'd1 && out_idx == 8'd2) && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    n_compared++;
    if (cyc >= 20) begin
      n_mismatched++;
      $display("[TB] FAIL reach_reg2: got tag=%0d idx=%0d, expected 1 2", out_tag, out_idx);
    end
    #2 rst = 1'b1;
    #1;
    n_compared++;
    if ({out_valid, out_data, out_tag, out_idx, reg_addr, mem_addr, busy, done, trig_lost} !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset: got %h, expected 0",
               {out_valid, out_data, out_tag, out_idx, reg_addr, mem_addr, busy, done, trig_lost});
    end
    saw_done = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done) saw_done = 1;
      rst = 1'b0;
    end
    n_compared++;
    if (saw_done) begin
      n_mismatched++;
      $display("[TB] FAIL abort_done: got 1, expected 0");
    end
    test_basic(32'h0000_0040);
  endtask

  task automatic test_reset_trig_high();
    int vc;
    rst = 1'b1;
    out_ready = 1'b0;
    trig = 1'b1;
    pc = 32'h0000_0C00;
    push_dump(pc);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    trig = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_compared++;
      if (out_valid !== 1'b1 || out_tag !== 2'd0 || out_data !== 32'h0000_0C00 || trig_lost !== 1'b0) begin
        n_mismatched++;
        $display("[TB] FAIL pc_held: got valid=%b tag=%0d data=%h lost=%b, expected 1 0 00000c00 0",
                 out_valid, out_tag, out_data, trig_lost);
      end
      @(negedge clk);
    end
    drain(1'b0, vc);
    n_compared++;
    if (trig_lost !== 1'b0 || done !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL lost_clear: got lost=%b done=%b, expected 0 1", trig_lost, done);
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NR; i++) regs[i] = DW'(i + 1);
    for (int i = 0; i < NM; i++) mem[i] = DW'(i + 10);
    $display("[TB] starting cpu_state_dumper bench");
    test_reset();
    test_basic(32'h0000_0040);
    test_backpressure();
    for (int i = 0; i < NR; i++) regs[i] = DW'(i + 1);
    for (int i = 0; i < NM; i++) mem[i] = DW'(i + 10);
    test_trig_held();
    test_reset_mid();
    test_reset_trig_high();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
